aes128_encrypt_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 110 +++++++++++
 rtl/aes_key_step.sv | 40 ++++
 rtl/aes128_encrypt_iter.sv | 127 ++++++++++++
 tb/tb_aes128_encrypt_iter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Shared AES-128 encryption helpers. Provides the S-box table,
//               xtime, round-constant lookup, state-byte slicing, the
//               SubBytes/ShiftRows/MixColumns transforms and the FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Encryption core control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] c_sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_sbox_table[8*(255 - int'(b)) +: 8];
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant for rounds 1..10; anything else yields zero
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Byte n of the state, byte 0 in bits [127:120]
    function automatic logic [7:0] state_byte(input logic [127:0] st, input int n);
        return st[127-8*n -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] st);
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[127-8*n -: 8] = sbox(state_byte(st, n));
        end
        return r;
    endfunction

    // Row r is rotated left by r columns
    function automatic logic [127:0] shift_rows(input logic [127:0] st);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(4*c+w) -: 8] = state_byte(st, 4*((c+w)%4) + w);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] st);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = state_byte(st, 4*c);
            a1 = state_byte(st, 4*c+1);
            a2 = state_byte(st, 4*c+2);
            a3 = state_byte(st, 4*c+3);
            r[127-32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[127-32*c-8    -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[127-32*c-16   -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[127-32*c-24   -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_step
// Description : Combinational AES-128 key schedule step: derives the next
//               round key from the current one and the round constant.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] i_rk,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_rk_n
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = i_rk[127:96];
    assign w_w1 = i_rk[95:64];
    assign w_w2 = i_rk[63:32];
    assign w_w3 = i_rk[31:0];

    // RotWord then SubWord on the last word of the previous key
    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                    sbox(w_rot[15:8]),  sbox(w_rot[7:0])};

    // Each new word chains on the one just produced
    assign w_n0 = w_w0 ^ w_sub ^ {i_rcon, 24'h000000};
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_rk_n = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes128_encrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes128_encrypt_iter
// Description : Iterative AES-128 encryption core. One full round per clock,
//               round keys expanded on the fly, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module aes128_encrypt_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes128_encrypt_iter supports only NR=10");
        end
    endgenerate

    localparam logic [3:0] c_nr_last = 4'(NR);

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_q, ct_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic [7:0]   w_rcon;
    logic [127:0] w_rk_next;
    logic [127:0] w_sb_sr;
    logic [127:0] w_round_out;

    assign w_rcon = rcon(rnd_q);

    aes_key_step u_key_step (
        .i_rk   (rk_q),
        .i_rcon (w_rcon),
        .o_rk_n (w_rk_next)
    );

    // The final round skips MixColumns
    assign w_sb_sr     = shift_rows(sub_bytes(st_q));
    assign w_round_out = ((rnd_q == c_nr_last) ? w_sb_sr : mix_columns(w_sb_sr)) ^ w_rk_next;

    // Next-state and datapath update for the IDLE -> ROUND -> DONE sequence
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rk_d        = rk_q;
        rnd_d       = rnd_q;
        ct_d        = ct_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    st_d       = plaintext ^ key;
                    rk_d       = key;
                    rnd_d      = 4'd1;
                    state_d    = ST_ROUND;
                    in_ready_d = 1'b0;
                end
            end
            ST_ROUND: begin
                st_d  = w_round_out;
                rk_d  = w_rk_next;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == c_nr_last) begin
                    ct_d        = w_round_out;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            rnd_q       <= '0;
            ct_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            rnd_q       <= rnd_d;
            ct_q        <= ct_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign ciphertext = ct_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_encrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes128_encrypt_iter
// Description : Self-checking bench for aes128_encrypt_iter with known-answer
//               vectors, handshake corner cases and a byte-level AES model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_encrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] ciphertext;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_m [256];

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_encrypt_iter #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (byte arrays, textbook AES) ----------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic       hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y  = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from the multiplicative inverse and affine map
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                          ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tw;
        logic [7:0]  rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sbox_m[tw[31:24]], sbox_m[tw[23:16]], sbox_m[tw[15:8]], sbox_m[tw[7:0]]}
                     ^ {rc, 24'h000000};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int b = 0; b < 16; b++) t[b] = sbox_m[s[b]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    t[0] = s[4*c]; t[1] = s[4*c+1]; t[2] = s[4*c+2]; t[3] = s[4*c+3];
                    s[4*c]   = gf_mul(t[0], 8'h02) ^ gf_mul(t[1], 8'h03) ^ t[2] ^ t[3];
                    s[4*c+1] = t[0] ^ gf_mul(t[1], 8'h02) ^ gf_mul(t[2], 8'h03) ^ t[3];
                    s[4*c+2] = t[0] ^ t[1] ^ gf_mul(t[2], 8'h02) ^ gf_mul(t[3], 8'h03);
                    s[4*c+3] = gf_mul(t[0], 8'h03) ^ t[1] ^ t[2] ^ gf_mul(t[3], 8'h02);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
        end
        res = '0;
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers (called at posedge+1) -----------------
    task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input bit disturb,
                             output logic [127:0] ct_out, output int lat);
        plaintext = pt; key = k; in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        in_valid = 1'b0; plaintext = rand128(); key = rand128();
        while (!out_valid && lat < 40) begin
            if (disturb) begin
                check_eq("busy_in_ready", 128'(in_ready), 128'(0));
                in_valid  = 1'($urandom);
                plaintext = rand128();
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        ct_out = ciphertext;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("drain_out_valid", 128'(out_valid), 128'(0));
        check_eq("drain_in_ready", 128'(in_ready), 128'(1));
    endtask

    // ---------------- main sequence ------------------------------------------
    initial begin
        logic [127:0] ct, ct_hold, pt_r, key_r;
        int           lat, idx, n_out, wait_c;
        logic [127:0] b2b_pt [3];
        logic [127:0] b2b_key [3];
        logic [127:0] b2b_ct [3];
        logic [127:0] got_ct [4];
        int           got_cyc [4];

        build_sbox();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_ct", ciphertext, 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 App.B with exact latency
        run_block(PT_B, KEY_B, 1'b0, ct, lat);
        check_eq("appb_ct", ct, CT_B);
        check_eq("appb_latency", 128'(lat), 128'(11));
        consume();

        // FIPS-197 App.C.1
        run_block(PT_C, KEY_C, 1'b0, ct, lat);
        check_eq("appc_ct", ct, CT_C);
        consume();

        // All-zero vector, then hold off the consumer
        run_block('0, '0, 1'b0, ct, lat);
        check_eq("zero_ct", ct, CT_Z);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check_eq("hold_out_valid", 128'(out_valid), 128'(1));
            check_eq("hold_ct", ciphertext, CT_Z);
            check_eq("hold_in_ready", 128'(in_ready), 128'(0));
        end
        consume();

        // Inputs toggled while busy must be ignored
        run_block(PT_C, KEY_C, 1'b1, ct, lat);
        check_eq("disturb_ct", ct, CT_C);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("done_in_ready", 128'(in_ready), 128'(0));
        check_eq("done_ct", ciphertext, CT_C);
        in_valid = 1'b0;
        consume();

        // Reset in the middle of a block
        plaintext = PT_C; key = KEY_C; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 128'(in_ready), 128'(1));
        check_eq("midrst_out_valid", 128'(out_valid), 128'(0));
        check_eq("midrst_ct", ciphertext, 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(PT_B, KEY_B, 1'b0, ct, lat);
        check_eq("postrst_ct", ct, CT_B);
        check_eq("postrst_latency", 128'(lat), 128'(11));
        consume();

        // Randomised blocks against the model, random consumer delay
        for (int n = 0; n < 10; n++) begin
            pt_r  = rand128();
            key_r = rand128();
            run_block(pt_r, key_r, 1'b0, ct, lat);
            check_eq("rand_ct", ct, model_encrypt(pt_r, key_r));
            check_eq("rand_latency", 128'(lat), 128'(11));
            ct_hold = model_encrypt(pt_r, key_r);
            wait_c = int'($urandom_range(0, 3));
            for (int i = 0; i < wait_c; i++) begin
                @(posedge clk); #1;
                check_eq("rand_hold_ct", ciphertext, ct_hold);
            end
            consume();
        end

        // Back-to-back with the consumer always ready
        b2b_pt[0] = PT_B; b2b_key[0] = KEY_B; b2b_ct[0] = CT_B;
        b2b_pt[1] = PT_C; b2b_key[1] = KEY_C; b2b_ct[1] = CT_C;
        b2b_pt[2] = '0;   b2b_key[2] = '0;    b2b_ct[2] = CT_Z;
        out_ready = 1'b1;
        idx = 0; n_out = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (out_valid && n_out < 4) begin
                got_ct[n_out]  = ciphertext;
                got_cyc[n_out] = cyc;
                n_out++;
            end
            if (in_ready && idx < 3) begin
                plaintext = b2b_pt[idx]; key = b2b_key[idx]; in_valid = 1'b1;
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check_eq("b2b_count", 128'(n_out), 128'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < n_out) check_eq("b2b_ct", got_ct[i], b2b_ct[i]);
            if (i > 0 && i < n_out) check_eq("b2b_period", 128'(got_cyc[i] - got_cyc[i-1]), 128'(12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
